// File: rtl/tb_dina_map.sv
// Maps systolic-array result vectors (or zero rows) into TB BRAM port-A writes at base+row.
// Latency: one cycle from vector accept (or zero-row issue) to the BRAM write strobe.
// Backpressure: res_ready is high only while a POS/NEG job runs; res_valid low simply stalls the job.
module tb_dina_map #(
   parameter int X      = 4,
   parameter int L      = 4,
   parameter int RSA_DW = 16,
   parameter int TB_AW  = 11
) (
   input  logic                  clk,
   input  logic                  sys_rst_n,
   input  logic                  start,
   input  logic [1:0]            dir_sel,
   input  logic [TB_AW-1:0]      base_addr,
   input  logic [TB_AW-1:0]      row_num,
   input  logic                  res_valid,
   input  logic [X*RSA_DW-1:0]   res_data,
   output logic                  res_ready,
   output logic                  TB_ena,
   output logic                  TB_wea,
   output logic [TB_AW-1:0]      TB_addra,
   output logic [L*RSA_DW-1:0]   TB_dina,
   output logic                  busy,
   output logic                  done
);

   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_POS  = 2'b01;
   localparam logic [1:0] DIR_NEG  = 2'b10;
   localparam logic [1:0] DIR_NEW  = 2'b11;
   localparam logic [TB_AW-1:0] ONE = {{(TB_AW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              state;
   logic [1:0]          dir_q;
   logic [TB_AW-1:0]    base_q;
   logic [TB_AW-1:0]    rows_q;
   logic [TB_AW-1:0]    cnt;
   logic [L*RSA_DW-1:0] mapped;
   logic                issue;
   logic                last_row;

   // Vector handshake and status flags are pure decodes of the registered state.
   assign res_ready = (state == S_RUN) && ((dir_q == DIR_POS) || (dir_q == DIR_NEG));
   assign busy      = (state == S_RUN);
   assign done      = (state == S_DONE);

   // A row goes out when a vector is accepted, or every RUN cycle for a zero-fill job.
   assign issue    = (state == S_RUN) && ((dir_q == DIR_NEW) || (res_valid && res_ready));
   assign last_row = (cnt == (rows_q - ONE));

   // Lane mapping: straight for POS, reversed for NEG; zero-fill and upper lanes stay 0.
   always_comb begin
      mapped = '0;
      for (int i = 0; i < X; i++) begin
         if (dir_q == DIR_POS)
            mapped[i*RSA_DW +: RSA_DW] = res_data[i*RSA_DW +: RSA_DW];
         else if (dir_q == DIR_NEG)
            mapped[i*RSA_DW +: RSA_DW] = res_data[(X-1-i)*RSA_DW +: RSA_DW];
      end
   end

   // Job FSM plus registered BRAM write port; strobes and data default low every cycle.
   always_ff @(posedge clk) begin
      if (!sys_rst_n) begin
         state    <= S_IDLE;
         dir_q    <= DIR_IDLE;
         base_q   <= '0;
         rows_q   <= '0;
         cnt      <= '0;
         TB_ena   <= 1'b0;
         TB_wea   <= 1'b0;
         TB_addra <= '0;
         TB_dina  <= '0;
      end else begin
         TB_ena  <= 1'b0;
         TB_wea  <= 1'b0;
         TB_dina <= '0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  dir_q  <= dir_sel;
                  base_q <= base_addr;
                  rows_q <= row_num;
                  cnt    <= '0;
                  // Empty or directionless jobs complete immediately without touching the BRAM.
                  if ((row_num == '0) || (dir_sel == DIR_IDLE))
                     state <= S_DONE;
                  else
                     state <= S_RUN;
               end
            end
            S_RUN: begin
               if (issue) begin
                  TB_ena   <= 1'b1;
                  TB_wea   <= 1'b1;
                  TB_addra <= base_q + cnt;
                  TB_dina  <= mapped;
                  cnt      <= cnt + ONE;
                  if (last_row)
                     state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tb_dina_map.sv
// Bench for tb_dina_map: directed and randomized jobs checked against a lane-list reference model.
// Every output cycle is logged; each job's writes, timing, done and busy are compared to the model.
module tb_tb_dina_map;

   localparam int X      = 4;
   localparam int L      = 6;
   localparam int RSA_DW = 16;
   localparam int TB_AW  = 11;
   localparam int DW     = RSA_DW;

   logic                  clk = 1'b0;
   logic                  sys_rst_n;
   logic                  start;
   logic [1:0]            dir_sel;
   logic [TB_AW-1:0]      base_addr;
   logic [TB_AW-1:0]      row_num;
   logic                  res_valid;
   logic [X*DW-1:0]       res_data;
   logic                  res_ready;
   logic                  TB_ena;
   logic                  TB_wea;
   logic [TB_AW-1:0]      TB_addra;
   logic [L*DW-1:0]       TB_dina;
   logic                  busy;
   logic                  done;

   tb_dina_map #(.X(X), .L(L), .RSA_DW(RSA_DW), .TB_AW(TB_AW)) dut (
      .clk(clk), .sys_rst_n(sys_rst_n), .start(start), .dir_sel(dir_sel),
      .base_addr(base_addr), .row_num(row_num), .res_valid(res_valid),
      .res_data(res_data), .res_ready(res_ready), .TB_ena(TB_ena), .TB_wea(TB_wea),
      .TB_addra(TB_addra), .TB_dina(TB_dina), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;
   int cyc    = 0;

   // per-job observation log
   int               wr_cyc[$];
   logic [TB_AW-1:0] wr_addr[$];
   logic [L*DW-1:0]  wr_dat[$];
   int               done_cyc[$];
   int               busy_n, rdy_seen, bad_idle;
   logic [TB_AW-1:0] prev_addr;
   logic [X*DW-1:0]  vecs[$];

   task automatic chk(input string tag, input logic [L*DW-1:0] obs, input logic [L*DW-1:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, then log what the outputs show for the new cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (TB_wea) begin
         wr_cyc.push_back(cyc);
         wr_addr.push_back(TB_addra);
         wr_dat.push_back(TB_dina);
         if (!TB_ena) bad_idle++;
      end else if (TB_ena || (TB_dina != '0) || (TB_addra != prev_addr)) begin
         bad_idle++;
      end
      prev_addr = TB_addra;
      if (done)      done_cyc.push_back(cyc);
      if (busy)      busy_n++;
      if (res_ready) rdy_seen++;
   endtask

   task automatic clear_log();
      wr_cyc.delete(); wr_addr.delete(); wr_dat.delete(); done_cyc.delete();
      busy_n = 0; rdy_seen = 0; bad_idle = 0;
   endtask

   // Reference: list of lanes, reversed for NEG, zero for NEW and lanes beyond X.
   function automatic logic [L*DW-1:0] model_map(input logic [1:0] dir, input logic [X*DW-1:0] v);
      logic [DW-1:0]   ln[$];
      logic [L*DW-1:0] r;
      r = '0;
      if (dir == 2'b11) return r;
      for (int i = 0; i < X; i++) ln.push_back(v[i*DW +: DW]);
      if (dir == 2'b10) ln.reverse();
      for (int i = 0; i < X; i++) r[i*DW +: DW] = ln[i];
      return r;
   endfunction

   // Run one job with vectors from vecs; gap = idle res_valid cycles between vectors.
   task automatic run_job(input string nm, input logic [1:0] dir, input int base, input int rows,
                          input int gap, input bit start_mid);
      int s, nw, period, guard, last;
      bit acc;
      clear_log();
      dir_sel = dir; base_addr = TB_AW'(base); row_num = TB_AW'(rows);
      start = 1'b1; res_valid = 1'b0;
      tick();
      s = cyc;
      start = 1'b0;
      // scramble config inputs: the job must use the latched copy
      dir_sel = 2'($urandom); base_addr = TB_AW'($urandom); row_num = TB_AW'($urandom);
      if ((dir == 2'b01 || dir == 2'b10) && rows > 0) begin
         for (int k = 0; k < rows; k++) begin
            if (k > 0) begin
               res_valid = 1'b0;
               res_data  = X*DW'($urandom);
               repeat (gap) tick();
            end
            res_valid = 1'b1;
            res_data  = vecs[k];
            if (start_mid && k == 1) start = 1'b1;
            acc = 1'b0; guard = 0;
            while (!acc && guard < 10) begin
               acc = res_ready;
               tick();
               guard++;
            end
            start = 1'b0;
            if (!acc) chk({nm, " accept timeout"}, 0, 1);
         end
         res_valid = 1'b0;
      end else if (dir == 2'b11) begin
         res_valid = 1'b1;
         res_data  = vecs[0];
         repeat (rows) tick();
         res_valid = 1'b0;
      end
      repeat (4) tick();

      nw     = (dir == 2'b00 || rows == 0) ? 0 : rows;
      period = (dir == 2'b11) ? 1 : gap + 1;
      last   = (nw == 0) ? s : s + 1 + (nw - 1) * period;
      chk({nm, " write count"}, wr_addr.size(), nw);
      for (int k = 0; k < nw && k < wr_addr.size(); k++) begin
         chk($sformatf("%s addr[%0d]", nm, k), wr_addr[k], (base + k) % (1 << TB_AW));
         chk($sformatf("%s data[%0d]", nm, k), wr_dat[k], model_map(dir, vecs[k]));
         chk($sformatf("%s cycle[%0d]", nm, k), wr_cyc[k], s + 1 + k * period);
      end
      chk({nm, " done pulses"}, done_cyc.size(), 1);
      if (done_cyc.size() > 0) chk({nm, " done cycle"}, done_cyc[0], last);
      chk({nm, " busy cycles"}, busy_n, last - s);
      chk({nm, " idle cycles clean"}, bad_idle, 0);
      if (dir == 2'b11) chk({nm, " ready stays low"}, rdy_seen, 0);
   endtask

   task automatic fill_random(input int n);
      vecs.delete();
      for (int k = 0; k < n; k++) vecs.push_back({$urandom, $urandom});
   endtask

   initial begin
      int dir, rows;
      sys_rst_n = 1'b0; start = 1'b0; dir_sel = 2'b00; base_addr = '0; row_num = '0;
      res_valid = 1'b0; res_data = '0; prev_addr = '0;
      clear_log();
      tick(); tick();
      chk("reset ena", TB_ena, 0);
      chk("reset wea", TB_wea, 0);
      chk("reset addra", TB_addra, 0);
      chk("reset dina", TB_dina, 0);
      chk("reset ready/busy/done", {res_ready, busy, done}, 0);
      sys_rst_n = 1'b1;
      tick();

      // POS, three back-to-back vectors {1,2,3,4}
      vecs.delete();
      repeat (3) vecs.push_back({16'd4, 16'd3, 16'd2, 16'd1});
      run_job("pos3", 2'b01, 'h010, 3, 0, 1'b0);

      // NEG single row
      vecs.delete();
      vecs.push_back({16'hD, 16'hC, 16'hB, 16'hA});
      run_job("neg1", 2'b10, 'h123, 1, 0, 1'b0);
      chk("neg1 lanes literal", (wr_dat.size() > 0) ? wr_dat[0] : '0,
          {32'h0, 16'hA, 16'hB, 16'hC, 16'hD});

      // POS with 2-cycle valid gaps
      fill_random(2);
      run_job("stall", 2'b01, 'h040, 2, 2, 1'b0);

      // zero-fill across the address wrap
      fill_random(1);
      run_job("new_wrap", 2'b11, 'h7FE, 4, 0, 1'b0);

      // degenerate jobs
      fill_random(1);
      run_job("rows0", 2'b01, 'h100, 0, 0, 1'b0);
      run_job("dir_idle", 2'b00, 'h100, 5, 0, 1'b0);

      // start re-asserted mid-job is ignored
      fill_random(3);
      run_job("start_mid", 2'b10, 'h200, 3, 1, 1'b1);

      // randomized jobs
      for (int j = 0; j < 8; j++) begin
         dir  = $urandom_range(1, 3);
         rows = $urandom_range(1, 5);
         fill_random(rows);
         run_job($sformatf("rnd%0d", j), 2'(dir), $urandom_range(0, (1 << TB_AW) - 1),
                 rows, $urandom_range(0, 2), 1'b0);
      end

      // reset after the first of three rows aborts the job
      fill_random(3);
      clear_log();
      dir_sel = 2'b01; base_addr = 'h300; row_num = 3; start = 1'b1;
      tick();
      start = 1'b0;
      res_valid = 1'b1; res_data = vecs[0];
      tick();
      res_data = vecs[1];
      sys_rst_n = 1'b0;
      tick();
      chk("abort ena/wea", {TB_ena, TB_wea}, 0);
      chk("abort addra", TB_addra, 0);
      chk("abort dina", TB_dina, 0);
      chk("abort ready/busy/done", {res_ready, busy, done}, 0);
      sys_rst_n = 1'b1;
      repeat (6) tick();
      res_valid = 1'b0;
      chk("abort write count", wr_addr.size(), 1);
      chk("abort done pulses", done_cyc.size(), 0);
      chk("abort busy after", busy, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/tb_dina_map.md
TB_DINA_MAP -- requirements
Module: tb_dina_map

Interface
REQ-001 SHALL have parameter X, default 4, meaning systolic-array result lanes.
REQ-002 SHALL have parameter L, default 4, meaning TB BRAM word lanes (L >= X).
REQ-003 SHALL have parameter RSA_DW, default 16, meaning lane data width.
REQ-004 SHALL have parameter TB_AW, default 11, meaning TB BRAM address width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port sys_rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port start, input, 1, one-cycle job request.
REQ-008 SHALL have port dir_sel, input, 2: 00 DIR_IDLE, 01 DIR_POS, 10 DIR_NEG, 11 DIR_NEW (zero-fill).
REQ-009 SHALL have port base_addr, input, TB_AW, first TB row address.
REQ-010 SHALL have port row_num, input, TB_AW, number of rows to write.
REQ-011 SHALL have port res_valid, input, 1, result vector valid.
REQ-012 SHALL have port res_data, input, X*RSA_DW, result vector; lane i is bits [i*RSA_DW +: RSA_DW].
REQ-013 SHALL have port res_ready, output, 1, result vector accepted when res_valid and res_ready are both high.
REQ-014 SHALL have ports TB_ena and TB_wea, output, 1 each, TB port-A enable and write enable.
REQ-015 SHALL have port TB_addra, output, TB_AW, TB port-A address.
REQ-016 SHALL have port TB_dina, output, L*RSA_DW, TB port-A write data.
REQ-017 SHALL have ports busy and done, output, 1 each, job in progress and one-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE.
REQ-019 In IDLE, start high SHALL latch dir_sel, base_addr and row_num, clear the row counter, and enter RUN. Exception: if row_num==0 or dir_sel==DIR_IDLE, it SHALL enter DONE.
REQ-020 start SHALL be ignored in RUN and DONE; busy SHALL be 1 exactly in RUN.
REQ-021 res_ready SHALL be 1 only in RUN with latched dir DIR_POS or DIR_NEG, combinationally from state.
REQ-022 Each accepted vector SHALL produce, on the next cycle, one write: TB_ena=TB_wea=1, TB_addra=base+cnt (mod 2^TB_AW), and mapped data.
REQ-023 Without an accept, the next cycle SHALL have TB_ena=TB_wea=0, TB_dina=0 and TB_addra holding its value.
REQ-024 The DIR_POS mapping SHALL be TB_dina lane i = res_data lane i for i<X.
REQ-025 The DIR_NEG mapping SHALL be TB_dina lane i = res_data lane X-1-i for i<X.
REQ-026 TB_dina lanes i>=X SHALL be 0.
REQ-027 With latched DIR_NEW, RUN SHALL write one all-zero row per cycle at base+cnt without consuming input, keeping res_ready=0.
REQ-028 The counter SHALL increment per write issued; after the row with cnt==row_num-1 is issued, the FSM SHALL enter DONE.
REQ-029 DONE SHALL last exactly one cycle with done=1, then return to IDLE. The last write and done SHALL be visible in the same cycle.
REQ-030 res_valid low in RUN SHALL stall the job indefinitely with no write and no counter change.
REQ-031 Address wrap past 2^TB_AW-1 SHALL go to 0 with no error.
REQ-032 Throughput SHALL be one row per cycle; latency from accept to write SHALL be 1 cycle.

Reset
REQ-033 When sys_rst_n==0 at a clock edge, all of the following SHALL be 0 on the next cycle: state=IDLE, counter, TB_ena, TB_wea, TB_addra, TB_dina, res_ready, busy, done.
REQ-034 Reset mid-job SHALL abort the job with no further writes; latched configuration is discarded.

Verification
REQ-035 POS job: base=0x010, row_num=3, three back-to-back vectors with lanes {1,2,3,4} -> writes at 0x010..0x012 with TB_dina lanes {1,2,3,4}; done high with the third write; busy 3 cycles.
REQ-036 NEG job: row_num=1, vector lanes {0xA,0xB,0xC,0xD} -> one write with TB_dina lanes {0xD,0xC,0xB,0xA}.
REQ-037 Stall: POS, row_num=2, res_valid gaps of 2 cycles between vectors -> exactly 2 writes; no TB_wea during gaps; counter frozen.
REQ-038 DIR_NEW: base=0x7FE, row_num=4, TB_AW=11 -> zero writes at 0x7FE, 0x7FF, 0x000, 0x001 on 4 consecutive cycles; res_ready stays 0.
REQ-039 Degenerate and abort cases:
- row_num=0, or dir_sel=DIR_IDLE -> done pulse one cycle after start, no writes.
- start asserted during RUN -> ignored.
- sys_rst_n low after 1 of 3 rows -> no further writes; all outputs 0.
